// File: rtl/or_bus_arbiter.sv
// or_bus_arbiter: round-robin owner sequencing of a shared AND-OR bus with burst limit
module or_bus_arbiter #(
    parameter int N         = 4,
    parameter int W         = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         last,
    input  logic [N*W-1:0]       data_in,
    output logic [N-1:0]         gnt,
    output logic                 bus_valid,
    output logic [W-1:0]         bus_data,
    output logic [$clog2(N)-1:0] bus_owner,
    output logic                 timeout
);
    localparam int OW = $clog2(N);
    localparam int CW = $clog2(MAX_BEATS + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BEATS - 1);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t         state, state_nx;
    logic [N-1:0]   gnt_nx;
    logic [OW-1:0]  owner_nx, ptr, ptr_nx, pick;
    logic [CW-1:0]  cnt, cnt_nx;
    logic           timeout_nx, found, last_o;
    assign bus_valid = |(gnt & req);
    assign last_o    = |(gnt & last);
    always_comb begin
        bus_data = '0;
        for (int i = 0; i < N; i++)
            bus_data = bus_data | (data_in[i*W +: W] & {W{gnt[i]}});
    end
    // descending scan so the requester closest to ptr wins
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                pick  = OW'((int'(ptr) + k) % N);
                found = 1'b1;
            end
        end
    end
    always_comb begin
        state_nx   = state;
        gnt_nx     = gnt;
        owner_nx   = bus_owner;
        ptr_nx     = ptr;
        cnt_nx     = cnt;
        timeout_nx = 1'b0;
        if (state == IDLE) begin
            if (found) begin
                state_nx = GRANT;
                gnt_nx   = N'(1) << pick;
                owner_nx = pick;
                cnt_nx   = '0;
            end
        end else if (!bus_valid || last_o || cnt == LAST_BEAT) begin
            state_nx   = IDLE;
            gnt_nx     = '0;
            owner_nx   = '0;
            ptr_nx     = (bus_owner == OW'(N - 1)) ? '0 : bus_owner + 1'b1;
            cnt_nx     = '0;
            timeout_nx = bus_valid && !last_o;
        end else begin
            cnt_nx = cnt + 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= '0;
            bus_owner <= '0;
            ptr       <= '0;
            cnt       <= '0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nx;
            gnt       <= gnt_nx;
            bus_owner <= owner_nx;
            ptr       <= ptr_nx;
            cnt       <= cnt_nx;
            timeout   <= timeout_nx;
        end
    end
endmodule
